// File: rtl/bcd_seq_conv.sv
// Iterative binary-to-BCD converter (shift-add-3), one input bit per clock.
// Results, overflow and leading-zero flags are registered on completion.
module bcd_seq_conv #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state_q;
  logic [BIN_W-1:0] sh_q;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   adj;
  logic [AW-1:0]   acc_d;
  logic [CW-1:0]   cnt_q;
  logic            of_q;
  logic            of_d;
  logic [DIGITS-1:0] blank_d;
  logic            zero_run;

  always_comb begin
    adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
    acc_d = {adj[AW-2:0], sh_q[BIN_W-1]};
    of_d  = of_q | adj[AW-1];
  end

  // Walk down from the top digit; a digit blanks only if all above it are zero.
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (acc_d[4*k +: 4] == 4'd0);
      blank_d[k] = zero_run & ~of_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      of_q       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      ovf        <= 1'b0;
      blank_mask <= BLANK_RST;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sh_q    <= bin_in;
            acc_q   <= '0;
            of_q    <= 1'b0;
            cnt_q   <= CW'(BIN_W);
            busy    <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          sh_q  <= sh_q << 1;
          acc_q <= acc_d;
          of_q  <= of_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q    <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            bcd_out    <= acc_d;
            ovf        <= of_d;
            blank_mask <= blank_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: three configurations checked against a
// decimal-arithmetic reference model.
module tb_bcd_seq_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  start_s = '0;
  logic [7:0]  bin8 = '0;
  logic [7:0]  bin2 = '0;
  logic [15:0] bin16 = '0;
  logic [2:0]  busy_s;
  logic [2:0]  done_s;
  logic [2:0]  ovf_s;
  logic [11:0] bcd8;
  logic [7:0]  bcd2;
  logic [19:0] bcd16;
  logic [2:0]  blank8;
  logic [1:0]  blank2;
  logic [4:0]  blank16;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  bcd_seq_conv #(.BIN_W(8), .DIGITS(3)) u8 (
    .clk(clk), .rst(rst), .start(start_s[0]), .bin_in(bin8),
    .busy(busy_s[0]), .done(done_s[0]), .bcd_out(bcd8),
    .ovf(ovf_s[0]), .blank_mask(blank8)
  );

  bcd_seq_conv #(.BIN_W(8), .DIGITS(2)) u2 (
    .clk(clk), .rst(rst), .start(start_s[1]), .bin_in(bin2),
    .busy(busy_s[1]), .done(done_s[1]), .bcd_out(bcd2),
    .ovf(ovf_s[1]), .blank_mask(blank2)
  );

  bcd_seq_conv #(.BIN_W(16), .DIGITS(5)) u16 (
    .clk(clk), .rst(rst), .start(start_s[2]), .bin_in(bin16),
    .busy(busy_s[2]), .done(done_s[2]), .bcd_out(bcd16),
    .ovf(ovf_s[2]), .blank_mask(blank16)
  );

  function automatic logic [19:0] ref_bcd(input longint v, input int d);
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic longint pow10(input int d);
    longint p;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [4:0] ref_blank(input longint v, input int d);
    logic [4:0] m;
    m = '0;
    if (v < pow10(d)) begin
      for (int k = 1; k < d; k++)
        if (v < pow10(k)) m[k] = 1'b1;
    end
    return m;
  endfunction

  // Drives one conversion on unit u and returns what the DUT reports.
  task automatic conv(input int u, input logic [15:0] v,
                      output logic [19:0] bcd, output logic o,
                      output logic [4:0] blank, output int lat,
                      output int bsy);
    start_s[u] = 1'b1;
    case (u)
      0: bin8 = v[7:0];
      1: bin2 = v[7:0];
      default: bin16 = v;
    endcase
    @(posedge clk); #1;
    start_s[u] = 1'b0;
    lat = 0;
    bsy = 0;
    while (!done_s[u] && lat < 40) begin
      if (busy_s[u]) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    case (u)
      0: begin bcd = {8'd0, bcd8}; blank = {2'd0, blank8}; end
      1: begin bcd = {12'd0, bcd2}; blank = {3'd0, blank2}; end
      default: begin bcd = bcd16; blank = blank16; end
    endcase
    o = ovf_s[u];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    vecs++;
    if (busy_s !== 3'b000 || done_s !== 3'b000 || ovf_s !== 3'b000) begin
      errs++;
      $display("FAIL reset_flags busy=%b done=%b ovf=%b want 000",
               busy_s, done_s, ovf_s);
    end
    vecs++;
    if (bcd8 !== 12'h0 || bcd2 !== 8'h0 || bcd16 !== 20'h0) begin
      errs++;
      $display("FAIL reset_bcd %h %h %h want 0", bcd8, bcd2, bcd16);
    end
    vecs++;
    if (blank8 !== 3'b110 || blank2 !== 2'b10 || blank16 !== 5'b11110) begin
      errs++;
      $display("FAIL reset_blank %b %b %b want 110 10 11110",
               blank8, blank2, blank16);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [19:0] b;
    logic o;
    logic [4:0] m;
    int lat, bsy;
    logic [15:0] vals [5];
    vals[0] = 16'd255; vals[1] = 16'd0; vals[2] = 16'd7;
    vals[3] = 16'd40;  vals[4] = 16'd100;
    for (int i = 0; i < 5 + 40; i++) begin
      logic [15:0] v;
      v = (i < 5) ? vals[i] : 16'($urandom_range(0, 255));
      conv(0, v, b, o, m, lat, bsy);
      vecs++;
      if (b[11:0] !== ref_bcd(v, 3) || o !== 1'b0 ||
          m[2:0] !== ref_blank(v, 3) ) begin
        errs++;
        $display("FAIL basic v=%0d bcd=%h ovf=%b blank=%b want %h 0 %b",
                 v, b[11:0], o, m[2:0], ref_bcd(v, 3), ref_blank(v, 3));
      end
      vecs++;
      if (lat !== 8 || bsy !== 8) begin
        errs++;
        $display("FAIL basic_timing v=%0d lat=%0d busy=%0d want 8 8",
                 v, lat, bsy);
      end
      @(posedge clk); #1;
      vecs++;
      if (done_s[0] !== 1'b0 || b[11:0] !== {4'd0, bcd8}) begin
        errs++;
        $display("FAIL done_pulse v=%0d done=%b bcd=%h want 0 held",
                 v, done_s[0], bcd8);
      end
    end
  endtask

  task automatic test_ovf();
    logic [19:0] b;
    logic o;
    logic [4:0] m;
    int lat, bsy;
    for (int i = 0; i < 42; i++) begin
      logic [15:0] v;
      v = (i == 0) ? 16'd150 : (i == 1) ? 16'd99 :
          16'($urandom_range(0, 255));
      conv(1, v, b, o, m, lat, bsy);
      vecs++;
      if (b[7:0] !== ref_bcd(v, 2) || o !== (v > 99) ||
          m[1:0] !== ref_blank(v, 2) || lat !== 8) begin
        errs++;
        $display("FAIL ovf v=%0d bcd=%h ovf=%b blank=%b lat=%0d want %h %b %b 8",
                 v, b[7:0], o, m[1:0], lat, ref_bcd(v, 2), v > 99,
                 ref_blank(v, 2));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] b;
    logic o;
    logic [4:0] m;
    int lat;
    int bsy;
    start_s[0] = 1'b1;
    bin8 = 8'd123;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    bin8 = 8'd77;
    @(posedge clk); @(posedge clk); #1;
    start_s[0] = 1'b1;
    bin8 = 8'd45;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    lat = 0;
    while (!done_s[0] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    vecs++;
    if (bcd8 !== 12'h123 || lat !== 5) begin
      errs++;
      $display("FAIL ignore_busy bcd=%h wait=%0d want 123 5", bcd8, lat);
    end
    conv(0, 16'd200, b, o, m, lat, bsy);
    vecs++;
    if (b[11:0] !== 12'h200 || lat !== 8) begin
      errs++;
      $display("FAIL back_to_back bcd=%h lat=%0d want 200 8", b[11:0], lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] b;
    logic o;
    logic [4:0] m;
    int lat, bsy;
    int seen;
    seen = 0;
    @(posedge clk); #1;
    start_s[0] = 1'b1;
    bin8 = 8'd99;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if (busy_s[0] !== 1'b0 || bcd8 !== 12'h0 || blank8 !== 3'b110) begin
      errs++;
      $display("FAIL reset_mid busy=%b bcd=%h blank=%b want 0 0 110",
               busy_s[0], bcd8, blank8);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (done_s[0]) seen++;
    end
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_s[0]) seen++;
    end
    vecs++;
    if (seen !== 0) begin
      errs++;
      $display("FAIL reset_mid_done pulses=%0d want 0", seen);
    end
    conv(0, 16'd88, b, o, m, lat, bsy);
    vecs++;
    if (b[11:0] !== 12'h088 || lat !== 8) begin
      errs++;
      $display("FAIL after_reset bcd=%h lat=%0d want 088 8", b[11:0], lat);
    end
  endtask

  task automatic test_sweep16();
    logic [19:0] b;
    logic o;
    logic [4:0] m;
    int lat, bsy;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] v;
      v = (i == 0) ? 16'hFFFF : (i == 1) ? 16'd0 :
          16'($urandom_range(0, 65535));
      conv(2, v, b, o, m, lat, bsy);
      vecs++;
      if (b !== ref_bcd(v, 5) || o !== 1'b0 || m !== ref_blank(v, 5) ||
          lat !== 16) begin
        errs++;
        $display("FAIL sweep16 v=%0d bcd=%h ovf=%b blank=%b lat=%0d want %h 0 %b 16",
                 v, b, o, m, lat, ref_bcd(v, 5), ref_blank(v, 5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    test_sweep16();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bcd_seq_conv.md
Name: bcd_seq_conv

Overview:
- Iterative, parametrised binary-to-BCD converter using shift-add-3 (double dabble). It processes one binary bit per clock.
- Replaces the combinational score converter in the display path. It drives the digit decoders of the seven-segment scan logic.
- Adds a start/done handshake, configurable input width and digit count, overflow detection, and leading-zero blanking flags.

Parameters:
- BIN_W, 8, width of the binary input in bits (range 1..32).
- DIGITS, 3, number of BCD output digits (range 1..10).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion of bin_in. Sampled on the rising edge of clk.
- bin_in  input  BIN_W  unsigned binary value. Captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse. Marks the cycle in which the new results become valid.
- bcd_out  output  4*DIGITS  packed BCD result. Digit k occupies bits [4k+3:4k], and digit 0 is the units digit.
- ovf  output  1  high when bin_in exceeded 10^DIGITS-1. Valid together with bcd_out.
- blank_mask  output  DIGITS  bit k is high when digit k is a leading zero. Digit 0 is never blanked.

Behaviour:
- Reset is asynchronous and active-high. While rst is high, outputs are held at:
  - busy=0, done=0, ovf=0
  - bcd_out=0
  - blank_mask = all ones except bit 0 = 0
  - FSM in IDLE
- Internal state:
  - shift register sh, BIN_W bits
  - working BCD register acc, 4*DIGITS bits
  - counter cnt, wide enough to hold BIN_W
  - sticky overflow bit of
- FSM states:
  - IDLE: busy=0. If start=1: sh<=bin_in, acc<=0, of<=0, cnt<=BIN_W, go to SHIFT, busy<=1.
  - SHIFT, once per clock:
    - Every acc digit whose value is >=5 gets +3.
    - The adjusted acc is shifted left by 1, and sh's MSB enters acc bit 0.
    - sh shifts left by 1. cnt decrements.
    - of <= of | (bit 4*DIGITS-1 of the adjusted acc), i.e. the bit shifted out of the top.
    - When cnt reaches 1 on this edge, the edge is the last shift and go to DONE.
  - DONE, single cycle:
    - On the edge entering DONE, bcd_out, ovf and blank_mask are registered from the final acc and of. done=1 and busy=0 in this cycle.
    - If start=1 in DONE, a new conversion is accepted exactly as in IDLE. Otherwise return to IDLE.
- Latency: the start edge loads the operands, and the next BIN_W edges perform the shifts. done is high in the cycle after the BIN_W-th shift edge. Throughput is one conversion per BIN_W+1 cycles.
- While busy=1, start is ignored and bin_in changes have no effect.
- bcd_out, ovf and blank_mask hold their last values until the next done. They never show intermediate values.
- Overflow: when ovf=1, bcd_out holds the low DIGITS decimal digits of bin_in, i.e. bin_in mod 10^DIGITS.
- blank_mask:
  - Bit k (k>=1) = 1 iff digits DIGITS-1 down to k are all zero in the registered result.
  - When ovf=1, blank_mask = 0, so all digits are shown.
- Reset mid-conversion aborts the conversion. done does not pulse, and the outputs return to their reset values.
- Correctness must hold for every BIN_W/DIGITS combination in range, including DIGITS*4 < BIN_W and DIGITS*4 > BIN_W.

Test Plan:
- BIN_W=8, DIGITS=3, bin_in=255, start for 1 cycle:
  - busy=1 for exactly 8 cycles.
  - Then done=1 for 1 cycle with bcd_out=0x255, ovf=0, blank_mask=3'b000.
- bin_in=0 -> bcd_out=0x000, blank_mask=3'b110. bin_in=7 -> bcd_out=0x007, blank_mask=3'b110. bin_in=40 -> bcd_out=0x040, blank_mask=3'b100.
- DIGITS=2, bin_in=150 -> ovf=1, bcd_out=0x50, blank_mask=2'b00. bin_in=99 -> ovf=0, bcd_out=0x99.
- Start bin_in=123. Pulse start with bin_in=45 during busy.
  - The second pulse is ignored, and the result is bcd_out=0x123.
  - Then start=1 in the done cycle with bin_in=200: accepted, and the next done shows 0x200.
- Assert rst in the 4th shift cycle of bin_in=99:
  - busy=0 immediately (asynchronous), bcd_out=0, no done pulse.
  - After release, conversion of 88 yields 0x088.
- BIN_W=16, DIGITS=5, random sweep of 1000 values -> bcd_out equals the reference decimal encoding, ovf=0, latency 16 cycles each.
